pmc_dc_bus_arbiter: RTL and testbench
=====================================

// Module: pmc_dc_bus_arbiter
// PURPOSE
//  Shares the single PMC digital-conf register bus (req/gnt/rvalid slave) between
//  N_MASTERS requesters (core data port, JTAG/debug loader, ...). Round-robin
//  arbitration per transfer; an owner FIFO routes each slave rvalid/rdata back to
//  the master that issued the granted request. Sits between masters and pmc_dc.
// PARAMETERS
//  N_MASTERS        2  number of requesters (>=2)
//  MAX_OUTSTANDING  2  granted-but-not-responded transfers allowed (>=1)
// PORTS
//  clk       in   1          clock; sole clock domain
//  rst       in   1          synchronous, active-high reset
//  m_req     in   N          per-master request
//  m_addr    in   N x 32     per-master address
//  m_we      in   N          per-master write enable
//  m_be      in   N x 4      per-master byte enables
//  m_wdata   in   N x 32     per-master write data
//  m_gnt     out  N          per-master grant (one-hot or zero)
//  m_rvalid  out  N          per-master response valid (one-hot or zero)
//  m_rdata   out  32         response data, broadcast = s_rdata
//  s_req     out  1          slave request
//  s_addr    out  32         slave address (mux of selected master)
//  s_we      out  1          slave write enable
//  s_be      out  4          slave byte enables
//  s_wdata   out  32         slave write data
//  s_gnt     in   1          slave grant (combinational, same cycle as s_req)
//  s_rvalid  in   1          slave response valid (>=1 cycle after s_gnt)
//  s_rdata   in   32         slave response data
//  err       out  1          sticky: s_rvalid seen with no outstanding transfer
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): rr_ptr=0, owner FIFO empty (count=0), err=0.
//    Hence m_gnt=0, m_rvalid=0, s_req=0 while no master requests after reset.
//  - Selection (comb): sel = first index i in rr_ptr, rr_ptr+1, ... (mod N) with
//    m_req[i]=1. s_addr/s_we/s_be/s_wdata = master sel; all-zero if none.
//  - s_req = |m_req && !blocked; blocked = (count==MAX_OUTSTANDING) && !s_rvalid
//    (a same-cycle pop frees a slot).
//  - Handshake hs = s_req && s_gnt. m_gnt[sel]=hs, all other m_gnt=0. Zero-latency
//    grant; masters hold req/addr/data until granted.
//  - On hs: push sel into owner FIFO; rr_ptr <= (sel+1) mod N. No hs: rr_ptr held.
//  - On s_rvalid with count>0: m_rvalid[head]=1 this cycle, m_rdata=s_rdata, pop.
//    Push and pop in one cycle: count unchanged, order preserved.
//  - On s_rvalid with count==0: no m_rvalid asserted, err <= 1 (held until rst).
//  - Responses are returned strictly in grant order (slave is in-order).
//  - Single requester: granted every cycle the slave grants (no bubbles).
//  - rst mid-transfer: FIFO flushed; responses arriving after reset count as
//    orphan (err=1). Integration resets slave and arbiter together.
//  - Widths: rr_ptr and FIFO entries $clog2(N_MASTERS) bits; count
//    $clog2(MAX_OUTSTANDING+1) bits; pointers wrap modulo MAX_OUTSTANDING.
// STRUCTURE
//  - pmc_dc_pkg: PMC_DC_ADDR_W=32, PMC_DC_DATA_W=32, PMC_DC_BE_W=4, and
//    typedef pmc_dc_bus_req_t {addr,we,be,wdata} used for m_* and s_* bundles.
//  - Sub-module pmc_dc_owner_fifo: sync FIFO (DEPTH=MAX_OUTSTANDING, WIDTH=
//    $clog2(N)), ports push/pop/din/dout/full/empty/count, rst synchronous.
//  - Arbiter core: comb rotate-priority select + rr_ptr register.
// TESTING
//  1 Reset: rst=1 for 2 cycles, all m_req=1 -> m_gnt=0,m_rvalid=0,err=0 during rst.
//  2 Fairness: N=2, m_req=2'b11 held, s_gnt=1, s_rvalid 1 cycle later ->
//    grants alternate m0,m1,m0,m1; each m_rvalid one cycle after its own m_gnt.
//  3 Back-pressure: MAX_OUTSTANDING=2, s_rvalid held 0 -> exactly 2 hs, then
//    s_req=0; s_rvalid pulse with m_req high -> pop and new grant same cycle.
//  4 Routing: m0 read addr 0x00, m1 write 0x04 granted back-to-back, slave replies
//    rdata 0xA5A5_0001 then 0x0 -> m_rvalid[0] with 0xA5A5_0001, then m_rvalid[1].
//  5 Orphan response: idle, s_rvalid=1 one cycle -> m_rvalid=0, err=1 sticky
//    until rst.
//  6 Reset mid-flight: 1 outstanding, rst=1 one cycle, then s_rvalid -> err=1, no
//    m_rvalid; rr_ptr back to 0 (m0 wins next 2'b11 request).

Source files
------------

// File: rtl/pmc_dc_pkg.sv
// Shared types and widths for the PMC digital-conf register bus.
package pmc_dc_pkg;

  localparam int PMC_DC_ADDR_W = 32;
  localparam int PMC_DC_DATA_W = 32;
  localparam int PMC_DC_BE_W   = 4;

  typedef struct packed {
    logic [PMC_DC_ADDR_W-1:0] addr;
    logic                     we;
    logic [PMC_DC_BE_W-1:0]   be;
    logic [PMC_DC_DATA_W-1:0] wdata;
  } pmc_dc_bus_req_t;

endpackage

// File: rtl/pmc_dc_owner_fifo.sv
// Small synchronous FIFO that remembers which master owns each granted transfer.
module pmc_dc_owner_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 1,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pmc_dc_bus_arbiter.sv
// Round-robin arbiter sharing the PMC digital-conf bus between several masters,
// routing in-order slave responses back to the master that owned each transfer.
module pmc_dc_bus_arbiter
  import pmc_dc_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_MASTERS-1:0]                     m_req,
  input  logic [N_MASTERS-1:0][PMC_DC_ADDR_W-1:0]  m_addr,
  input  logic [N_MASTERS-1:0]                     m_we,
  input  logic [N_MASTERS-1:0][PMC_DC_BE_W-1:0]    m_be,
  input  logic [N_MASTERS-1:0][PMC_DC_DATA_W-1:0]  m_wdata,
  output logic [N_MASTERS-1:0]                     m_gnt,
  output logic [N_MASTERS-1:0]                     m_rvalid,
  output logic [PMC_DC_DATA_W-1:0]                 m_rdata,
  output logic                                     s_req,
  output logic [PMC_DC_ADDR_W-1:0]                 s_addr,
  output logic                                     s_we,
  output logic [PMC_DC_BE_W-1:0]                   s_be,
  output logic [PMC_DC_DATA_W-1:0]                 s_wdata,
  input  logic                                     s_gnt,
  input  logic                                     s_rvalid,
  input  logic [PMC_DC_DATA_W-1:0]                 s_rdata,
  output logic                                     err
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   head;
  logic            found;
  int              idx;
  pmc_dc_bus_req_t s_bus;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            blocked;
  logic            hs;
  logic            pop;
  logic            orphan;

  // Rotating-priority search starting at rr_ptr.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      cand = IW'(idx);
      if (!found && m_req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    s_bus = '0;
    if (found) begin
      s_bus.addr  = m_addr[sel];
      s_bus.we    = m_we[sel];
      s_bus.be    = m_be[sel];
      s_bus.wdata = m_wdata[sel];
    end
  end

  assign s_addr  = s_bus.addr;
  assign s_we    = s_bus.we;
  assign s_be    = s_bus.be;
  assign s_wdata = s_bus.wdata;
  assign m_rdata = s_rdata;

  // Reset masks the combinational handshake so nothing is granted or returned mid-reset.
  assign blocked = fifo_full && !s_rvalid;
  assign s_req   = found && !blocked && !rst;
  assign hs      = s_req && s_gnt;
  assign pop     = s_rvalid && (fifo_count != '0) && !rst;
  assign orphan  = s_rvalid && fifo_empty;

  always_comb begin
    m_gnt    = '0;
    m_rvalid = '0;
    if (hs)  m_gnt[sel]     = 1'b1;
    if (pop) m_rvalid[head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      if (hs)     rr_ptr <= (sel == IW'(N_MASTERS - 1)) ? '0 : sel + IW'(1);
      if (orphan) err    <= 1'b1;
    end
  end

  pmc_dc_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_owner_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs),
    .pop   (pop),
    .din   (sel),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_pmc_dc_bus_arbiter.sv
// Randomized scoreboard bench for pmc_dc_bus_arbiter with a queue-based reference model.
module tb_pmc_dc_bus_arbiter;
  import pmc_dc_pkg::*;

  localparam int N    = 2;
  localparam int MAXO = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        m_req;
  logic [N-1:0][31:0]  m_addr;
  logic [N-1:0]        m_we;
  logic [N-1:0][3:0]   m_be;
  logic [N-1:0][31:0]  m_wdata;
  logic [N-1:0]        m_gnt;
  logic [N-1:0]        m_rvalid;
  logic [31:0]         m_rdata;
  logic                s_req;
  logic [31:0]         s_addr;
  logic                s_we;
  logic [3:0]          s_be;
  logic [31:0]         s_wdata;
  logic                s_gnt;
  logic                s_rvalid;
  logic [31:0]         s_rdata;
  logic                err;

  always #5 clk = ~clk;

  pmc_dc_bus_arbiter #(
    .N_MASTERS       (N),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_wdata  (m_wdata),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_we     (s_we),
    .s_be     (s_be),
    .s_wdata  (s_wdata),
    .s_gnt    (s_gnt),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata),
    .err      (err)
  );

  typedef struct {
    int          owner;
    logic [31:0] data;
  } exp_t;

  // Reference model: owners in grant order, slave's pending read data, master intents.
  exp_t        sb_q[$];
  int          own_q[$];
  logic [31:0] slave_q[$];
  bit          mreq[N];
  logic [31:0] maddr[N];
  bit          mwe[N];
  logic [3:0]  mbe[N];
  logic [31:0] mwdata[N];
  int          rr;
  bit          exp_err;
  bit          exp_hs;
  int          exp_sel;
  int          compared   = 0;
  int          mismatched = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit anyReq();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= mreq[i];
    return a;
  endfunction

  task automatic driveMasters();
    for (int i = 0; i < N; i++) begin
      m_req[i]   = mreq[i];
      m_addr[i]  = maddr[i];
      m_we[i]    = mwe[i];
      m_be[i]    = mbe[i];
      m_wdata[i] = mwdata[i];
    end
  endtask

  // Expected outputs for the current inputs, derived from the arbitration rules.
  task automatic checkOutput();
    bit          any;
    bit          exp_sreq;
    logic [31:0] ea, ew, eb, ed;
    any     = 1'b0;
    exp_sel = 0;
    for (int k = 0; k < N; k++) begin
      int j = (rr + k) % N;
      if (!any && mreq[j]) begin
        any     = 1'b1;
        exp_sel = j;
      end
    end
    exp_sreq = any && !(own_q.size() == MAXO && !s_rvalid);
    exp_hs   = exp_sreq && s_gnt;
    ea = any ? maddr[exp_sel]         : 32'd0;
    ew = any ? 32'(mwe[exp_sel])      : 32'd0;
    eb = any ? 32'(mbe[exp_sel])      : 32'd0;
    ed = any ? mwdata[exp_sel]        : 32'd0;
    cmp("s_req",   32'(s_req), 32'(exp_sreq));
    cmp("m_gnt",   32'(m_gnt), exp_hs ? (32'd1 << exp_sel) : 32'd0);
    cmp("s_addr",  s_addr, ea);
    cmp("s_we",    32'(s_we), ew);
    cmp("s_be",    32'(s_be), eb);
    cmp("s_wdata", s_wdata, ed);
    cmp("rvalid_present", 32'(m_rvalid != '0), 32'(s_rvalid && own_q.size() > 0));
    cmp("m_rdata", m_rdata, s_rdata);
    cmp("err",     32'(err), 32'(exp_err));
  endtask

  task automatic applyStimulus(input int req_pct, input int gnt_pct, input int rv_pct, input bit orphan);
    bit          from_slave;
    logic [31:0] d;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!mreq[i] && $urandom_range(99) < req_pct) begin
        mreq[i]   = 1'b1;
        maddr[i]  = $urandom() & 32'hFFFF_FFFC;
        mwe[i]    = 1'($urandom_range(1));
        mbe[i]    = 4'($urandom_range(15));
        mwdata[i] = $urandom();
      end
    end
    driveMasters();
    s_gnt      = ($urandom_range(99) < gnt_pct);
    from_slave = 1'b0;
    if (orphan) begin
      s_rvalid = 1'b1;
      s_rdata  = $urandom();
    end else if (slave_q.size() > 0 && $urandom_range(99) < rv_pct) begin
      s_rvalid   = 1'b1;
      s_rdata    = slave_q[0];
      from_slave = 1'b1;
    end else begin
      s_rvalid = 1'b0;
      s_rdata  = $urandom();
    end
    #1;
    checkOutput();
    if (s_rvalid) begin
      if (from_slave) void'(slave_q.pop_front());
      if (own_q.size() > 0) void'(own_q.pop_front());
      else exp_err = 1'b1;
    end
    if (exp_hs) begin
      d = $urandom();
      own_q.push_back(exp_sel);
      slave_q.push_back(d);
      sb_q.push_back('{owner: exp_sel, data: d});
      rr = (exp_sel + 1) % N;
      mreq[exp_sel] = 1'b0;
    end
  endtask

  task automatic doReset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst      = 1'b1;
      m_req    = '1;
      s_gnt    = 1'b1;
      s_rvalid = 1'b0;
      s_rdata  = '0;
      #1;
      cmp("rst_m_gnt",    32'(m_gnt), 32'd0);
      cmp("rst_m_rvalid", 32'(m_rvalid), 32'd0);
      cmp("rst_s_req",    32'(s_req), 32'd0);
      if (c > 0) cmp("rst_err", 32'(err), 32'd0);
    end
    rr      = 0;
    exp_err = 1'b0;
    own_q.delete();
    sb_q.delete();
    for (int i = 0; i < N; i++) mreq[i] = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && (slave_q.size() > 0 || anyReq()); c++)
      applyStimulus(0, 100, 100, 1'b0);
    applyStimulus(0, 100, 0, 1'b0);
    cmp("drain_done", 32'(slave_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (m_rvalid != '0) begin
        if (sb_q.size() == 0) begin
          cmp("rsp_unexpected", 32'(m_rvalid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          cmp("rsp_owner", 32'(m_rvalid), 32'd1 << e.owner);
          cmp("rsp_rdata", m_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      mreq[i] = 1'b0; maddr[i] = '0; mwe[i] = 1'b0; mbe[i] = '0; mwdata[i] = '0;
    end
    driveMasters();
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    rr = 0; exp_err = 1'b0;

    doReset(2);

    for (int c = 0; c < 8; c++) applyStimulus(100, 100, 100, 1'b0);

    for (int c = 0; c < 4; c++) applyStimulus(100, 100, 0, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(100, 100, 100, 1'b0);

    for (int blk = 0; blk < 30; blk++) begin
      int rp = $urandom_range(10, 100);
      int gp = $urandom_range(30, 100);
      int vp = $urandom_range(10, 90);
      for (int c = 0; c < 50; c++) applyStimulus(rp, gp, vp, 1'b0);
    end

    drain();
    applyStimulus(0, 100, 0, 1'b1);
    for (int c = 0; c < 3; c++) applyStimulus(0, 100, 0, 1'b0);

    doReset(1);
    mreq[0] = 1'b1; maddr[0] = 32'h0000_0010; mwe[0] = 1'b0; mbe[0] = 4'hF; mwdata[0] = '0;
    applyStimulus(0, 100, 0, 1'b0);
    doReset(1);
    applyStimulus(0, 100, 100, 1'b0);
    applyStimulus(100, 100, 0, 1'b0);
    cmp("post_rst_winner", 32'(m_gnt), 32'd1);
    drain();
    cmp("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
